// File: rtl/dds_wave_gen.sv
// rtl/dds_wave_gen.sv - phase-accumulator waveform generator with shadowed configuration
//
// Generates sine, triangle, square and sawtooth samples from a phase
// accumulator, scales them by an 8-bit amplitude and emits one sample per
// enabled cycle. Configuration is double-buffered: a load fills the shadow
// set, which becomes active at the next accumulator wrap (en=1) or on the
// next cycle (en=0), so a running waveform only changes at a period boundary.
//
// Ports:
//   clk_100kHz  in   1        sole clock, rising edge
//   rst_        in   1        asynchronous active-high reset
//   en          in   1        advance phase and emit a sample
//   load        in   1        capture cfg_* into the shadow configuration
//   cfg_freq    in   PHASE_W  frequency tuning word (phase increment)
//   cfg_wave    in   2        0 sine, 1 triangle, 2 square, 3 sawtooth
//   cfg_duty    in   OUT_W    square wave is high while T < duty
//   cfg_amp     in   8        amplitude scale, out = raw*(amp+1)>>8
//   wave_out    out  OUT_W    offset-binary sample, holds when not valid
//   out_valid   out  1        wave_out carries a new sample
//   sync        out  1        first sample of each waveform period
//   cfg_pending out  1        shadow configuration awaiting application

module dds_wave_gen #(
   parameter int PHASE_W = 16,
   parameter int OUT_W   = 8,
   parameter int LUT_AW  = 8
) (
   input  logic               clk_100kHz,
   input  logic               rst_,
   input  logic               en,
   input  logic               load,
   input  logic [PHASE_W-1:0] cfg_freq,
   input  logic [1:0]         cfg_wave,
   input  logic [OUT_W-1:0]   cfg_duty,
   input  logic [7:0]         cfg_amp,
   output logic [OUT_W-1:0]   wave_out,
   output logic               out_valid,
   output logic               sync,
   output logic               cfg_pending
);

   // Only the top SB phase bits feed the waveform logic, so the sampled
   // phase register keeps just those.
   localparam int SB = ((OUT_W + 1) > LUT_AW) ? (OUT_W + 1) : LUT_AW;
   localparam int QA = LUT_AW - 2;
   localparam int QN = 1 << QA;
   localparam int PW = OUT_W + 9;

   localparam logic [1:0] WAVE_SINE = 2'd0;
   localparam logic [1:0] WAVE_TRI  = 2'd1;
   localparam logic [1:0] WAVE_SQR  = 2'd2;
   localparam logic [1:0] WAVE_SAW  = 2'd3;

   localparam logic [OUT_W-1:0] DUTY_RST = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [7:0]       AMP_RST  = 8'hFF;

   // ------------------------------------------------------------------
   // Quarter-wave sine table: entry i = round((2^(OUT_W-1)-0.5)*(1+sin(2*pi*i/2^LUT_AW)))
   // Evaluated from constants only, so it folds to a ROM.
   // ------------------------------------------------------------------
   function automatic logic [OUT_W-1:0] sine_entry(input int idx);
      real half;
      real ang;
      half = (2.0 ** (OUT_W - 1)) - 0.5;
      ang  = 2.0 * 3.14159265358979323846 * $itor(idx) / (2.0 ** LUT_AW);
      return OUT_W'($rtoi(half * (1.0 + $sin(ang)) + 0.5));
   endfunction

   logic [OUT_W-1:0] quarter_lut [QN];

   for (genvar gi = 0; gi < QN; gi++) begin : g_lut
      assign quarter_lut[gi] = sine_entry(gi);
   end

   // ------------------------------------------------------------------
   // Active and shadow configuration
   // ------------------------------------------------------------------
   logic [PHASE_W-1:0] freq_a, freq_s;
   logic [1:0]         wave_a, wave_s;
   logic [OUT_W-1:0]   duty_a, duty_s;
   logic [7:0]         amp_a,  amp_s;

   logic [PHASE_W-1:0] phase;
   logic               post_wrap;
   logic [PHASE_W:0]   phase_sum;
   logic               wrap;
   logic               apply;

   // Next active values: a load landing on the wrap edge goes straight to
   // active; otherwise the shadow set is promoted.
   logic [PHASE_W-1:0] nxt_freq;
   logic [1:0]         nxt_wave;
   logic [OUT_W-1:0]   nxt_duty;
   logic [7:0]         nxt_amp;

   assign phase_sum = {1'b0, phase} + {1'b0, freq_a};
   assign wrap      = en & phase_sum[PHASE_W];
   assign apply     = wrap | (~en & cfg_pending);

   always_comb begin
      nxt_freq = freq_s;
      nxt_wave = wave_s;
      nxt_duty = duty_s;
      nxt_amp  = amp_s;
      if (wrap && load) begin
         nxt_freq = cfg_freq;
         nxt_wave = cfg_wave;
         nxt_duty = cfg_duty;
         nxt_amp  = cfg_amp;
      end
   end

   always_ff @(posedge clk_100kHz or posedge rst_) begin
      if (rst_) begin
         freq_a      <= '0;
         wave_a      <= WAVE_SINE;
         duty_a      <= DUTY_RST;
         amp_a       <= AMP_RST;
         freq_s      <= '0;
         wave_s      <= WAVE_SINE;
         duty_s      <= DUTY_RST;
         amp_s       <= AMP_RST;
         cfg_pending <= 1'b0;
      end else begin
         if (load) begin
            freq_s <= cfg_freq;
            wave_s <= cfg_wave;
            duty_s <= cfg_duty;
            amp_s  <= cfg_amp;
         end
         if (apply) begin
            freq_a <= nxt_freq;
            wave_a <= nxt_wave;
            duty_a <= nxt_duty;
            amp_a  <= nxt_amp;
         end
         // When idle, a load that coincides with promotion of the old
         // shadow still needs its own promotion next cycle.
         if (wrap) begin
            cfg_pending <= 1'b0;
         end else if (!en && cfg_pending) begin
            cfg_pending <= load;
         end else if (load) begin
            cfg_pending <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Phase accumulator. post_wrap marks that the current phase value was
   // produced by a wrapping add, i.e. it is the first phase of a period.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_100kHz or posedge rst_) begin
      if (rst_) begin
         phase     <= '0;
         post_wrap <= 1'b0;
      end else if (en) begin
         phase     <= phase_sum[PHASE_W-1:0];
         post_wrap <= phase_sum[PHASE_W];
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: sample the phase that this enabled cycle represents, with
   // the configuration in force for it, so a config swap at a wrap edge
   // never mixes old and new settings within one sample.
   // ------------------------------------------------------------------
   logic [SB-1:0]    s1_ph;
   logic             s1_v;
   logic             s1_sync;
   logic [1:0]       s1_wave;
   logic [OUT_W-1:0] s1_duty;
   logic [7:0]       s1_amp;

   always_ff @(posedge clk_100kHz or posedge rst_) begin
      if (rst_) begin
         s1_ph   <= '0;
         s1_v    <= 1'b0;
         s1_sync <= 1'b0;
         s1_wave <= WAVE_SINE;
         s1_duty <= DUTY_RST;
         s1_amp  <= AMP_RST;
      end else begin
         s1_v    <= en;
         s1_sync <= en & post_wrap;
         if (en) begin
            s1_ph   <= phase[PHASE_W-1 -: SB];
            s1_wave <= wave_a;
            s1_duty <= duty_a;
            s1_amp  <= amp_a;
         end
      end
   end

   // ------------------------------------------------------------------
   // Raw waveform from the sampled phase
   // ------------------------------------------------------------------
   logic [OUT_W-1:0]  t_val;
   logic [OUT_W-1:0]  a_val;
   logic [LUT_AW-1:0] k_val;
   logic [QA-1:0]     q_idx;
   logic [QA-1:0]     q_mir;
   logic [OUT_W-1:0]  sine_raw;
   logic [OUT_W-1:0]  raw_val;

   always_comb begin
      t_val = s1_ph[SB-1 -: OUT_W];
      a_val = s1_ph[SB-2 -: OUT_W];
      k_val = s1_ph[SB-1 -: LUT_AW];
      q_idx = k_val[QA-1:0];
      q_mir = QA'(0) - q_idx;

      // Quadrant folding. Index 0 of the odd quadrants sits on the peak or
      // trough, which the quarter table (0..QN-1) does not hold; index 0 of
      // the third quadrant is the midpoint, which must not be inverted.
      case (k_val[LUT_AW-1 -: 2])
         2'd0:    sine_raw = quarter_lut[q_idx];
         2'd1:    sine_raw = (q_idx == '0) ? '1 : quarter_lut[q_mir];
         2'd2:    sine_raw = (q_idx == '0) ? quarter_lut[q_idx] : ~quarter_lut[q_idx];
         default: sine_raw = (q_idx == '0) ? '0 : ~quarter_lut[q_mir];
      endcase

      case (s1_wave)
         WAVE_SINE: raw_val = sine_raw;
         WAVE_TRI:  raw_val = s1_ph[SB-1] ? ~a_val : a_val;
         WAVE_SQR:  raw_val = (t_val < s1_duty) ? '1 : '0;
         default:   raw_val = t_val;
      endcase
   end

   // ------------------------------------------------------------------
   // Stage 2: raw sample
   // ------------------------------------------------------------------
   logic [OUT_W-1:0] s2_raw;
   logic             s2_v;
   logic             s2_sync;
   logic [7:0]       s2_amp;

   always_ff @(posedge clk_100kHz or posedge rst_) begin
      if (rst_) begin
         s2_raw  <= '0;
         s2_v    <= 1'b0;
         s2_sync <= 1'b0;
         s2_amp  <= AMP_RST;
      end else begin
         s2_v    <= s1_v;
         s2_sync <= s1_v & s1_sync;
         if (s1_v) begin
            s2_raw <= raw_val;
            s2_amp <= s1_amp;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: amplitude scaling. amp+1 is 1..256, so amp=255 yields
   // raw*256>>8 = raw and the product never exceeds OUT_W bits after >>8.
   // ------------------------------------------------------------------
   logic [PW-1:0] prod;

   always_comb begin
      prod = PW'(s2_raw) * PW'({1'b0, s2_amp} + 9'd1);
   end

   always_ff @(posedge clk_100kHz or posedge rst_) begin
      if (rst_) begin
         wave_out  <= '0;
         out_valid <= 1'b0;
         sync      <= 1'b0;
      end else begin
         out_valid <= s2_v;
         sync      <= s2_v & s2_sync;
         if (s2_v) begin
            wave_out <= OUT_W'(prod >> 8);
         end
      end
   end

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb/tb_dds_wave_gen.sv - scoreboard testbench for dds_wave_gen
module tb_dds_wave_gen;

   localparam int PHASE_W = 16;
   localparam int OUT_W   = 8;
   localparam int LUT_AW  = 8;

   logic               clk_100kHz = 1'b0;
   logic               rst_;
   logic               en;
   logic               load;
   logic [PHASE_W-1:0] cfg_freq;
   logic [1:0]         cfg_wave;
   logic [OUT_W-1:0]   cfg_duty;
   logic [7:0]         cfg_amp;
   logic [OUT_W-1:0]   wave_out;
   logic               out_valid;
   logic               sync;
   logic               cfg_pending;

   always #5 clk_100kHz = ~clk_100kHz;

   dds_wave_gen #(
      .PHASE_W (PHASE_W),
      .OUT_W   (OUT_W),
      .LUT_AW  (LUT_AW)
   ) dut (
      .clk_100kHz  (clk_100kHz),
      .rst_        (rst_),
      .en          (en),
      .load        (load),
      .cfg_freq    (cfg_freq),
      .cfg_wave    (cfg_wave),
      .cfg_duty    (cfg_duty),
      .cfg_amp     (cfg_amp),
      .wave_out    (wave_out),
      .out_valid   (out_valid),
      .sync        (sync),
      .cfg_pending (cfg_pending)
   );

   typedef struct {
      logic [OUT_W-1:0] val;
      logic             syn;
      int               due;
   } exp_t;

   exp_t sb[$];
   int   n_total;
   int   n_bad;
   int   edge_n;
   logic [OUT_W-1:0] last_wave;

   logic [PHASE_W-1:0] m_phase;
   logic               m_post_wrap;
   logic               m_pending;
   logic [PHASE_W-1:0] a_freq, s_freq;
   logic [1:0]         a_wave, s_wave;
   logic [OUT_W-1:0]   a_duty, s_duty;
   logic [7:0]         a_amp,  s_amp;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
      n_total++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", tag, act, want, edge_n);
      end
   endtask

   function automatic logic [OUT_W-1:0] model_sample(input logic [PHASE_W-1:0] ph,
                                                     input logic [1:0] w,
                                                     input logic [OUT_W-1:0] d,
                                                     input logic [7:0] a);
      logic [OUT_W-1:0] t;
      logic [OUT_W-1:0] tri_v;
      logic [OUT_W-1:0] raw;
      int               k;
      real              r;
      t     = ph[PHASE_W-1 -: OUT_W];
      tri_v = ph[PHASE_W-1] ? ~ph[PHASE_W-2 -: OUT_W] : ph[PHASE_W-2 -: OUT_W];
      k     = int'(ph >> (PHASE_W - LUT_AW));
      r     = ((2.0 ** (OUT_W - 1)) - 0.5) *
              (1.0 + $sin(2.0 * 3.141592653589793 * k / (2.0 ** LUT_AW)));
      case (w)
         2'd0:    raw = OUT_W'($rtoi(r + 0.5));
         2'd1:    raw = tri_v;
         2'd2:    raw = (t < d) ? '1 : '0;
         default: raw = t;
      endcase
      return OUT_W'((int'(raw) * (int'(a) + 1)) >> 8);
   endfunction

   task automatic model_reset();
      m_phase     = '0;
      m_post_wrap = 1'b0;
      m_pending   = 1'b0;
      a_freq = '0;  a_wave = 2'd0; a_duty = 8'h80; a_amp = 8'hFF;
      s_freq = '0;  s_wave = 2'd0; s_duty = 8'h80; s_amp = 8'hFF;
      sb.delete();
      last_wave = '0;
   endtask

   task automatic model_edge(input logic e, input logic l);
      logic [PHASE_W:0] sum;
      logic             w;
      exp_t             x;
      if (e) begin
         x.val = model_sample(m_phase, a_wave, a_duty, a_amp);
         x.syn = m_post_wrap;
         x.due = edge_n + 3;
         sb.push_back(x);
      end
      sum = {1'b0, m_phase} + {1'b0, a_freq};
      w   = e & sum[PHASE_W];
      if (w) begin
         if (l) begin
            a_freq = cfg_freq; a_wave = cfg_wave; a_duty = cfg_duty; a_amp = cfg_amp;
         end else begin
            a_freq = s_freq; a_wave = s_wave; a_duty = s_duty; a_amp = s_amp;
         end
         m_pending = 1'b0;
      end else if (!e && m_pending) begin
         a_freq = s_freq; a_wave = s_wave; a_duty = s_duty; a_amp = s_amp;
         m_pending = l;
      end else if (l) begin
         m_pending = 1'b1;
      end
      if (l) begin
         s_freq = cfg_freq; s_wave = cfg_wave; s_duty = cfg_duty; s_amp = cfg_amp;
      end
      if (e) begin
         m_phase     = sum[PHASE_W-1:0];
         m_post_wrap = w;
      end
   endtask

   task automatic check_outputs();
      exp_t x;
      if (sb.size() != 0 && sb[0].due == edge_n) begin
         x = sb.pop_front();
         chk("out_valid", 32'(out_valid), 32'd1);
         chk("wave_out", 32'(wave_out), 32'(x.val));
         chk("sync", 32'(sync), 32'(x.syn));
         last_wave = x.val;
      end else begin
         chk("idle_valid", 32'(out_valid), 32'd0);
         chk("idle_sync", 32'(sync), 32'd0);
         chk("hold_wave", 32'(wave_out), 32'(last_wave));
      end
      chk("cfg_pending", 32'(cfg_pending), 32'(m_pending));
   endtask

   task automatic tick(input logic e, input logic l);
      en   = e;
      load = l;
      model_edge(e, l);
      @(posedge clk_100kHz);
      edge_n++;
      @(negedge clk_100kHz);
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
   endtask

   task automatic set_cfg(input logic [PHASE_W-1:0] f, input logic [1:0] w,
                          input logic [OUT_W-1:0] d, input logic [7:0] a);
      cfg_freq = f;
      cfg_wave = w;
      cfg_duty = d;
      cfg_amp  = a;
   endtask

   task automatic random_segment(input int n);
      logic [PHASE_W-1:0] f;
      logic               e;
      logic               l;
      for (int i = 0; i < n; i++) begin
         l = ($urandom_range(0, 15) == 0);
         e = ($urandom_range(0, 7) != 0);
         if (l) begin
            if ($urandom_range(0, 7) == 0) f = PHASE_W'($urandom_range(0, 3));
            else f = PHASE_W'($urandom_range(1, 16'hFFFF));
            set_cfg(f, 2'($urandom_range(0, 3)), OUT_W'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)));
         end
         tick(e, l);
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_total = 0;
      n_bad   = 0;
      edge_n  = 0;
      rst_    = 1'b1;
      en      = 1'b0;
      load    = 1'b0;
      set_cfg('0, 2'd0, 8'h80, 8'hFF);
      model_reset();
      repeat (3) @(posedge clk_100kHz);
      @(negedge clk_100kHz);
      rst_ = 1'b0;

      chk("rst_wave", 32'(wave_out), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_sync", 32'(sync), 32'd0);
      chk("rst_pending", 32'(cfg_pending), 32'd0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);

      // sawtooth, configured while idle
      set_cfg(16'h0100, 2'd3, 8'h80, 8'hFF);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      run(600);

      // triangle, takes over at the next wrap
      set_cfg(16'h0080, 2'd1, 8'h80, 8'hFF);
      tick(1'b1, 1'b1);
      run(1100);

      // square, full and reduced amplitude
      set_cfg(16'h0100, 2'd2, 8'h40, 8'hFF);
      tick(1'b1, 1'b1);
      run(600);
      set_cfg(16'h0100, 2'd2, 8'h40, 8'h7F);
      tick(1'b1, 1'b1);
      run(600);

      // sine at a quarter of the phase range per sample
      set_cfg(16'h4000, 2'd0, 8'h80, 8'hFF);
      tick(1'b1, 1'b1);
      run(300);

      // mid-period frequency changes, second load overrides the first
      set_cfg(16'h0100, 2'd3, 8'h80, 8'hFF);
      tick(1'b1, 1'b1);
      run(100);
      set_cfg(16'h0200, 2'd3, 8'h80, 8'hFF);
      tick(1'b1, 1'b1);
      run(20);
      set_cfg(16'h0300, 2'd3, 8'h80, 8'hFF);
      tick(1'b1, 1'b1);
      run(400);

      // enable gaps keep the pipeline and hold behaviour honest
      repeat (5) tick(1'b0, 1'b0);
      run(50);

      // zero frequency freezes phase; pending load waits until en drops
      set_cfg(16'h0000, 2'd3, 8'h80, 8'hFF);
      tick(1'b1, 1'b1);
      run(300);
      set_cfg(16'h0100, 2'd1, 8'h80, 8'hC0);
      tick(1'b1, 1'b1);
      run(50);
      tick(1'b0, 1'b0);
      run(100);

      random_segment(3000);

      // asynchronous reset between edges with a load pending
      set_cfg(16'h0100, 2'd3, 8'h80, 8'hFF);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      run(50);
      set_cfg(16'h0040, 2'd1, 8'h20, 8'h10);
      tick(1'b1, 1'b1);
      run(3);
      en   = 1'b0;
      load = 1'b0;
      #2 rst_ = 1'b1;
      #1;
      model_reset();
      chk("arst_wave", 32'(wave_out), 32'd0);
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_sync", 32'(sync), 32'd0);
      chk("arst_pending", 32'(cfg_pending), 32'd0);
      @(posedge clk_100kHz);
      @(negedge clk_100kHz);
      chk("arst_hold_valid", 32'(out_valid), 32'd0);
      chk("arst_hold_pending", 32'(cfg_pending), 32'd0);
      #2 rst_ = 1'b0;
      @(negedge clk_100kHz);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      run(10);
      set_cfg(16'h0100, 2'd3, 8'h80, 8'hFF);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      run(300);

      repeat (5) tick(1'b0, 1'b0);
      chk("drain", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/dds_wave_gen.md
DDS_WAVE_GEN -- requirements
Module: dds_wave_gen

Interface
REQ-001 SHALL have parameter PHASE_W, default 16, phase accumulator width (>= LUT_AW+2).
REQ-002 SHALL have parameter OUT_W, default 8, sample width (<= PHASE_W-1).
REQ-003 SHALL have parameter LUT_AW, default 8, sine table phase resolution (full-cycle address bits).
REQ-004 SHALL have port clk_100kHz  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  phase advance enable.
REQ-007 SHALL have port load  input  1  configuration load strobe.
REQ-008 SHALL have port cfg_freq  input  PHASE_W  frequency tuning word.
REQ-009 SHALL have port cfg_wave  input  2  0 sine, 1 triangle, 2 square, 3 sawtooth.
REQ-010 SHALL have port cfg_duty  input  OUT_W  square-wave high threshold.
REQ-011 SHALL have port cfg_amp  input  8  amplitude scale.
REQ-012 SHALL have port wave_out  output  OUT_W  offset-binary sample, registered.
REQ-013 SHALL have port out_valid  output  1  wave_out carries a sample.
REQ-014 SHALL have port sync  output  1  one-cycle pulse aligned with the first sample of each cycle.
REQ-015 SHALL have port cfg_pending  output  1  loaded configuration awaiting application.

Function
REQ-016 SHALL hold active registers freq, wave, duty, amp and shadow registers of the same fields.
REQ-017 On load=1, SHALL capture all cfg_* into shadow and set cfg_pending next cycle; a load while pending overwrites shadow.
REQ-018 With en=1, SHALL apply shadow to active and clear cfg_pending on the cycle the accumulator wraps; if load coincides with a wrap, the new cfg_* values SHALL be applied at that wrap.
REQ-019 With en=0, SHALL apply pending shadow on the next cycle (no wrap expected).
REQ-020 Phase SHALL update as phase <= phase + freq mod 2^PHASE_W when en=1, and hold when en=0; wrap = carry-out of this add.
REQ-021 SHALL form T = phase[PHASE_W-1 -: OUT_W] (sawtooth), A = phase[PHASE_W-2 -: OUT_W].
REQ-022 Sawtooth raw = T; triangle raw = phase MSB ? ~A : A; square raw = (T < duty) ? all-ones : 0.
REQ-023 Sine raw = round((2^(OUT_W-1)-0.5)*(1+sin(2*pi*k/2^LUT_AW))), k = phase[PHASE_W-1 -: LUT_AW], from an internal quarter-wave table of 2^(LUT_AW-2) entries, using symmetry; results SHALL equal the full-table values.
REQ-024 Output SHALL be wave_out = (raw * (amp+1)) >> 8, truncated; amp=255 passes raw unchanged.
REQ-025 Pipeline SHALL be three registered stages (phase, raw, scaled); latency from phase update to wave_out is 2 cycles after phase register.
REQ-026 out_valid SHALL rise 3 cycles after first en=1 after reset and follow en delayed 3 cycles; wave_out holds when not valid.
REQ-027 sync SHALL be the wrap event delayed to align with the sample at phase post-wrap; never asserted when out_valid=0.
REQ-028 cfg_freq=0 SHALL freeze the phase while en=1 with no wrap; pending configuration then waits (no wrap).

Reset
REQ-029 rst_=1 SHALL asynchronously clear phase, pipeline, wave_out=0, out_valid=0, sync=0, cfg_pending=0.
REQ-030 Reset SHALL set active and shadow to freq=0, wave=0, duty=2^(OUT_W-1), amp=255.
REQ-031 Reset asserted mid-operation SHALL discard any pending load; first output after release follows REQ-026.

Verification
REQ-032 Defaults, load freq=0x0100 wave=3 amp=255 with en=0, then en=1 -> wave_out 0x00,0x01,0x02... one step per cycle, sync every 256 samples, out_valid from 3rd cycle.
REQ-033 Triangle freq=0x0080, wave=1 -> wave_out ramps 0x00..0xFF over 256 cycles then 0xFF..0x00; sync at period 512.
REQ-034 Square duty=0x40 freq=0x0100 -> 64 samples 0xFF, 192 samples 0x00 per period; amp=0x7F -> high level 0x7F.
REQ-035 Sine freq=0x4000 -> repeating 0x80,0xFF,0x80,0x00 (after rounding table values); sync on each 0x80 after wrap.
REQ-036 Load freq change mid-period -> cfg_pending=1 until wrap, old frequency until sync, new after; second load before wrap overrides first.
REQ-037 Assert rst_ asynchronously between edges mid-period with pending load -> all outputs 0 immediately, cfg_pending=0, restart per REQ-026.
